// File: rtl/game_sprite_engine.sv
`default_nettype none
// ============================================================================
// Module   : game_sprite_engine
// Purpose  : Multi-sprite renderer. Per-pixel hit test on frame-synchronised
//            active positions, per-sprite bitmaps with optional mirroring,
//            fixed-priority merge (lowest index wins), per-frame collision and
//            off-screen reporting. Two-cycle latency from pixel_x/pixel_y.
// Revision : 1.0 - initial release
// ============================================================================
module game_sprite_engine #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int SPRITE_WIDTH  = 8,
  parameter int SPRITE_HEIGHT = 8,
  parameter int X_WIDTH       = 10,
  parameter int Y_WIDTH       = 10,
  parameter int RGB_WIDTH     = 3,
  parameter int NUM_SPRITES   = 4,
  localparam int SID_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int ROW_W = $clog2(SPRITE_HEIGHT),
  localparam int COL_W = $clog2(SPRITE_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   frame_start,
  input  logic [X_WIDTH-1:0]     pixel_x,
  input  logic [Y_WIDTH-1:0]     pixel_y,
  input  logic                   bm_we,
  input  logic [SID_W-1:0]       bm_sprite,
  input  logic [ROW_W-1:0]       bm_row,
  input  logic [COL_W-1:0]       bm_col,
  input  logic [RGB_WIDTH:0]     bm_ergb,
  input  logic                   pos_we,
  input  logic [SID_W-1:0]       pos_sprite,
  input  logic [X_WIDTH-1:0]     pos_x,
  input  logic [Y_WIDTH-1:0]     pos_y,
  input  logic [2:0]             pos_attr,
  output logic                   rgb_en,
  output logic [RGB_WIDTH-1:0]   rgb,
  output logic [SID_W-1:0]       hit_id,
  output logic [NUM_SPRITES-1:0] collision,
  output logic [NUM_SPRITES-1:0] out_of_screen
);

  // Extents and screen limits, held one bit wider than the coordinates so
  // that sprites near the top of the coordinate range clip instead of wrap.
  localparam logic [X_WIDTH:0] X_SPAN  = (X_WIDTH+1)'(SPRITE_WIDTH - 1);
  localparam logic [Y_WIDTH:0] Y_SPAN  = (Y_WIDTH+1)'(SPRITE_HEIGHT - 1);
  localparam logic [X_WIDTH:0] X_LIMIT = (X_WIDTH+1)'(SCREEN_WIDTH - 1);
  localparam logic [Y_WIDTH:0] Y_LIMIT = (Y_WIDTH+1)'(SCREEN_HEIGHT - 1);

  // Attribute bit positions within {enable, flip_y, flip_x}
  localparam int ATTR_FLIP_X = 0;
  localparam int ATTR_FLIP_Y = 1;
  localparam int ATTR_EN     = 2;

  logic [NUM_SPRITES-1:0] contrib;      // stage 2: hit and opaque
  logic [NUM_SPRITES-1:0] oos_now;      // off-screen, from active registers
  logic [RGB_WIDTH-1:0]   pix_rgb [NUM_SPRITES];
  logic [RGB_WIDTH-1:0]   win_rgb;
  logic [SID_W-1:0]       win_id;
  logic                   multi;
  logic [NUM_SPRITES-1:0] coll_now;
  logic [NUM_SPRITES-1:0] coll_acc;

  generate
    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_sprite
      localparam logic [SID_W-1:0] SID = SID_W'(i);

      logic [X_WIDTH-1:0] shadow_x, active_x;
      logic [Y_WIDTH-1:0] shadow_y, active_y;
      logic [2:0]         shadow_attr, active_attr;

      logic [X_WIDTH:0]   x_end;
      logic [Y_WIDTH:0]   y_end;
      logic               in_x, in_y, hit_now;
      logic [COL_W-1:0]   col_off, col_now;
      logic [ROW_W-1:0]   row_off, row_now;

      logic               hit_s1;
      logic [COL_W-1:0]   col_s1;
      logic [ROW_W-1:0]   row_s1;

      logic [RGB_WIDTH:0] mem [SPRITE_HEIGHT*SPRITE_WIDTH];
      logic [RGB_WIDTH:0] pix;

      assign x_end = {1'b0, active_x} + X_SPAN;
      assign y_end = {1'b0, active_y} + Y_SPAN;
      assign in_x  = ({1'b0, pixel_x} >= {1'b0, active_x}) && ({1'b0, pixel_x} <= x_end);
      assign in_y  = ({1'b0, pixel_y} >= {1'b0, active_y}) && ({1'b0, pixel_y} <= y_end);
      assign hit_now = active_attr[ATTR_EN] & in_x & in_y;

      // Low bits of the offset only depend on low bits of the operands;
      // mirroring a power-of-two index is a bitwise inversion.
      assign col_off = pixel_x[COL_W-1:0] - active_x[COL_W-1:0];
      assign row_off = pixel_y[ROW_W-1:0] - active_y[ROW_W-1:0];
      assign col_now = active_attr[ATTR_FLIP_X] ? ~col_off : col_off;
      assign row_now = active_attr[ATTR_FLIP_Y] ? ~row_off : row_off;

      assign oos_now[i] = active_attr[ATTR_EN] & ((x_end > X_LIMIT) | (y_end > Y_LIMIT));

      // Shadow/active position registers and stage-1 hit/address pipeline
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          shadow_x    <= '0;
          shadow_y    <= '0;
          shadow_attr <= '0;
          active_x    <= '0;
          active_y    <= '0;
          active_attr <= '0;
          hit_s1      <= 1'b0;
          col_s1      <= '0;
          row_s1      <= '0;
        end else begin
          if (pos_we && (pos_sprite == SID)) begin
            shadow_x    <= pos_x;
            shadow_y    <= pos_y;
            shadow_attr <= pos_attr;
          end
          if (frame_start) begin
            active_x    <= shadow_x;
            active_y    <= shadow_y;
            active_attr <= shadow_attr;
          end
          hit_s1 <= hit_now;
          col_s1 <= col_now;
          row_s1 <= row_now;
        end
      end

      // Bitmap storage; contents are deliberately not reset
      always_ff @(posedge clk) begin
        if (bm_we && (bm_sprite == SID)) begin
          mem[{bm_row, bm_col}] <= bm_ergb;
        end
      end

      // Stage-2 read: a same-cycle write is not yet visible here
      assign pix        = mem[{row_s1, col_s1}];
      assign contrib[i] = hit_s1 & pix[RGB_WIDTH];
      assign pix_rgb[i] = pix[RGB_WIDTH-1:0];
    end
  endgenerate

  // Fixed-priority select: scanning downward leaves the lowest index last
  always_comb begin
    win_rgb = '0;
    win_id  = '0;
    for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
      if (contrib[k]) begin
        win_rgb = pix_rgb[k];
        win_id  = SID_W'(k);
      end
    end
  end

  // More than one contributor: clearing the lowest set bit leaves something
  assign multi    = |(contrib & (contrib - NUM_SPRITES'(1)));
  assign coll_now = multi ? contrib : '0;

  // Stage-2 output registers, collision accumulation and off-screen flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_en        <= 1'b0;
      rgb           <= '0;
      hit_id        <= '0;
      collision     <= '0;
      coll_acc      <= '0;
      out_of_screen <= '0;
    end else begin
      rgb_en <= |contrib;
      if (|contrib) begin
        rgb    <= win_rgb;
        hit_id <= win_id;
      end
      if (frame_start) begin
        collision <= coll_acc;
        coll_acc  <= coll_now;
      end else begin
        coll_acc  <= coll_acc | coll_now;
      end
      out_of_screen <= oos_now;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_game_sprite_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_sprite_engine
// Purpose  : Directed and randomized stimulus for game_sprite_engine, checked
//            cycle by cycle against a behavioural model of sprites on screen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_sprite_engine;

  localparam int SW = 8;
  localparam int SH = 8;
  localparam int NS = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       frame_start;
  logic [9:0] pixel_x, pixel_y;
  logic       bm_we;
  logic [1:0] bm_sprite;
  logic [2:0] bm_row, bm_col;
  logic [3:0] bm_ergb;
  logic       pos_we;
  logic [1:0] pos_sprite;
  logic [9:0] pos_x, pos_y;
  logic [2:0] pos_attr;
  logic       rgb_en;
  logic [2:0] rgb;
  logic [1:0] hit_id;
  logic [3:0] collision, out_of_screen;

  int tests = 0;
  int fails = 0;

  game_sprite_engine dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .bm_we(bm_we), .bm_sprite(bm_sprite), .bm_row(bm_row), .bm_col(bm_col), .bm_ergb(bm_ergb),
    .pos_we(pos_we), .pos_sprite(pos_sprite), .pos_x(pos_x), .pos_y(pos_y), .pos_attr(pos_attr),
    .rgb_en(rgb_en), .rgb(rgb), .hit_id(hit_id),
    .collision(collision), .out_of_screen(out_of_screen)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int         act_x[NS], act_y[NS], sh_x[NS], sh_y[NS];
  logic [2:0] act_a[NS], sh_a[NS];
  logic [3:0] bmp[NS][SH][SW];
  bit         p_hit[NS];
  int         p_row[NS], p_col[NS];
  logic       e_en;
  logic [2:0] e_rgb;
  logic [1:0] e_id;
  logic [3:0] e_coll, e_oos, acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rgb_en"}, 32'(rgb_en), 32'(e_en));
    check({tag, ".rgb"}, 32'(rgb), 32'(e_rgb));
    check({tag, ".hit_id"}, 32'(hit_id), 32'(e_id));
    check({tag, ".collision"}, 32'(collision), 32'(e_coll));
    check({tag, ".out_of_screen"}, 32'(out_of_screen), 32'(e_oos));
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < NS; i++) begin
      act_x[i] = 0; act_y[i] = 0; act_a[i] = 3'b000;
      sh_x[i] = 0;  sh_y[i] = 0;  sh_a[i] = 3'b000;
      p_hit[i] = 1'b0;
    end
    e_en = 1'b0; e_rgb = '0; e_id = '0; e_coll = '0; e_oos = '0; acc = '0;
  endtask

  task automatic idle();
    frame_start = 1'b0;
    bm_we       = 1'b0;
    pos_we      = 1'b0;
  endtask

  // One clock: predict what the outputs become at this edge, then compare.
  task automatic tick(input string tag);
    logic [3:0] bits;
    int cnt, w, px, py, dx, dy;
    bits = '0; cnt = 0; w = -1;
    // Pixel presented last cycle: which opaque sprite pixels cover it
    for (int i = 0; i < NS; i++) begin
      if (p_hit[i]) begin
        if (bmp[i][p_row[i]][p_col[i]][3]) begin
          bits[i] = 1'b1;
          cnt++;
          if (w < 0) w = i;
        end
      end
    end
    e_en = (cnt > 0);
    if (w >= 0) begin
      e_rgb = bmp[w][p_row[w]][p_col[w]][2:0];
      e_id  = w[1:0];
    end
    if (frame_start) begin
      e_coll = acc;
      acc    = (cnt > 1) ? bits : 4'b0000;
    end else if (cnt > 1) begin
      acc = acc | bits;
    end
    for (int i = 0; i < NS; i++)
      e_oos[i] = act_a[i][2] && ((act_x[i] + SW - 1 > 639) || (act_y[i] + SH - 1 > 479));
    // Pixel presented now, judged against the positions currently on screen
    px = int'(pixel_x);
    py = int'(pixel_y);
    for (int i = 0; i < NS; i++) begin
      dx = px - act_x[i];
      dy = py - act_y[i];
      p_hit[i] = act_a[i][2] && dx >= 0 && dx < SW && dy >= 0 && dy < SH;
      p_col[i] = act_a[i][0] ? (SW - 1 - dx) : dx;
      p_row[i] = act_a[i][1] ? (SH - 1 - dy) : dy;
    end
    // State updates taking effect at this edge
    if (bm_we) bmp[bm_sprite][bm_row][bm_col] = bm_ergb;
    if (frame_start)
      for (int i = 0; i < NS; i++) begin
        act_x[i] = sh_x[i]; act_y[i] = sh_y[i]; act_a[i] = sh_a[i];
      end
    if (pos_we) begin
      sh_x[pos_sprite] = int'(pos_x);
      sh_y[pos_sprite] = int'(pos_y);
      sh_a[pos_sprite] = pos_attr;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic wbm(input int s, input int r, input int c, input logic [3:0] v);
    bm_we = 1'b1; bm_sprite = 2'(s); bm_row = 3'(r); bm_col = 3'(c); bm_ergb = v;
    tick("bmwrite");
    bm_we = 1'b0;
  endtask

  task automatic set_pos(input int s, input int x, input int y, input logic [2:0] a, input bit fs);
    pos_we = 1'b1; pos_sprite = 2'(s); pos_x = 10'(x); pos_y = 10'(y); pos_attr = a;
    frame_start = fs;
    tick("setpos");
    pos_we = 1'b0; frame_start = 1'b0;
  endtask

  task automatic fstart();
    frame_start = 1'b1;
    tick("frame_start");
    frame_start = 1'b0;
  endtask

  // Sweep a horizontal run then let the pipeline drain at an empty pixel
  task automatic sweep(input string tag, input int x0, input int x1, input int y);
    for (int x = x0; x <= x1; x++) begin
      pixel_x = 10'(x); pixel_y = 10'(y);
      tick(tag);
    end
    pixel_x = 10'd700; pixel_y = 10'd600;
    tick(tag);
    tick(tag);
  endtask

  task automatic mid_reset();
    #1 reset_n = 1'b0;
    #1;
    check("midrst.rgb_en", 32'(rgb_en), 32'd0);
    check("midrst.rgb", 32'(rgb), 32'd0);
    check("midrst.hit_id", 32'(hit_id), 32'd0);
    check("midrst.collision", 32'(collision), 32'd0);
    check("midrst.out_of_screen", 32'(out_of_screen), 32'd0);
    mdl_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    pixel_x = 10'd700; pixel_y = 10'd600;
    bm_sprite = '0; bm_row = '0; bm_col = '0; bm_ergb = '0;
    pos_sprite = '0; pos_x = '0; pos_y = '0; pos_attr = '0;
    repeat (2) @(posedge clk);
    #1;
    mdl_reset();
    check_all("reset");
    reset_n = 1'b1;

    // Bitmaps: sprite 0 solid 1101, sprite 1 only column 0 opaque (1010),
    // sprite 2 solid 1011, sprite 3 solid 1110
    for (int r = 0; r < SH; r++)
      for (int c = 0; c < SW; c++) begin
        wbm(0, r, c, 4'b1101);
        wbm(1, r, c, (c == 0) ? 4'b1010 : 4'b0010);
        wbm(2, r, c, 4'b1011);
        wbm(3, r, c, 4'b1110);
      end

    // Sprite 0 at (100,50): not visible until the frame boundary
    set_pos(0, 100, 50, 3'b100, 1'b0);
    sweep("s0_pending", 99, 108, 50);
    fstart();
    sweep("s0_sweep", 99, 108, 50);
    sweep("s0_bottom", 99, 108, 57);
    sweep("s0_below", 99, 108, 58);

    // Reset in the middle of a frame while sprite 0 is being drawn
    pixel_x = 10'd102; pixel_y = 10'd52;
    tick("pre_rst");
    mid_reset();
    sweep("post_rst", 99, 108, 50);
    fstart();
    sweep("post_rst_fs", 99, 108, 50);

    // Sprite 1 mirrored in X at the origin: only column 7 on screen is opaque
    set_pos(1, 0, 0, 3'b101, 1'b0);
    fstart();
    sweep("flipx", 0, 9, 3);
    set_pos(1, 0, 0, 3'b011, 1'b0);
    fstart();
    sweep("flipx_disabled", 0, 9, 3);

    // Sprites 0 and 2 overlap; sprite 0 wins, collision reported next frame
    set_pos(0, 200, 200, 3'b100, 1'b0);
    set_pos(2, 204, 200, 3'b100, 1'b0);
    fstart();
    sweep("overlap", 198, 213, 201);
    fstart();
    check("collision_0101", 32'(collision), 32'h5);
    set_pos(2, 300, 300, 3'b100, 1'b0);
    fstart();
    sweep("no_overlap", 198, 213, 201);
    fstart();
    check("collision_0000", 32'(collision), 32'h0);

    // Sprite 3 straddling the bottom-right corner
    set_pos(3, 636, 476, 3'b100, 1'b0);
    sweep("s3_pending", 630, 639, 478);
    frame_start = 1'b1;
    tick("s3_fs");
    frame_start = 1'b0;
    check("oos_before", 32'(out_of_screen[3]), 32'd0);
    tick("s3_next");
    check("oos_after", 32'(out_of_screen[3]), 32'd1);
    sweep("s3_sweep", 630, 639, 478);

    // Clipping at the top of the coordinate range
    set_pos(1, 1020, 10, 3'b100, 1'b0);
    fstart();
    sweep("clip_hi", 1016, 1023, 12);
    sweep("clip_lo", 0, 4, 12);

    // Position write in the frame_start cycle lands one frame later
    set_pos(0, 400, 300, 3'b110, 1'b1);
    sweep("samecyc_pending", 398, 409, 305);
    fstart();
    sweep("samecyc_visible", 398, 409, 305);

    // Randomized traffic concentrated on a small screen region and the edges
    for (int n = 0; n < 3000; n++) begin
      frame_start = ($urandom_range(0, 39) == 0);
      pos_we      = ($urandom_range(0, 7) == 0);
      pos_sprite  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       pos_x = 10'($urandom_range(1012, 1023));
        1:       pos_x = 10'($urandom_range(630, 639));
        default: pos_x = 10'($urandom_range(0, 40));
      endcase
      case ($urandom_range(0, 7))
        0:       pos_y = 10'($urandom_range(1012, 1023));
        1:       pos_y = 10'($urandom_range(470, 479));
        default: pos_y = 10'($urandom_range(0, 40));
      endcase
      pos_attr  = {($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3))};
      bm_we     = ($urandom_range(0, 3) == 0);
      bm_sprite = 2'($urandom_range(0, 3));
      bm_row    = 3'($urandom_range(0, 7));
      bm_col    = 3'($urandom_range(0, 7));
      bm_ergb   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) begin
        pixel_x = 10'($urandom_range(1010, 1023));
        pixel_y = 10'($urandom_range(1010, 1023));
      end else begin
        pixel_x = 10'($urandom_range(0, 48));
        pixel_y = 10'($urandom_range(0, 48));
      end
      tick("random");
    end
    idle();
    tick("drain");
    tick("drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
